timer_unit: RTL and testbench
=============================

Name: timer_unit

Overview:
Memory-mapped down-counting timer on the SoC data bus, in parallel with the data memory and decoded by address. It sources the CPU's timer interrupt line `intimer`, which is bit 0 of the 6-bit `intr` vector. Software programs reload, prescale and control registers with ordinary load/store accesses, and clears the interrupt by writing 1 to STATUS.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte base address of the register window. The window is 32 bytes, aligned.
- CNT_W, 32, width of LOAD/COUNT registers (≤32). Upper rdData bits read 0.
- PRE_W, 16, width of PRESCALE register.

Ports:
- clk  in  1  system clock. All state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  bus access strobe, same signal as the data memory chip enable.
- we  in  1  write enable, valid when ce=1.
- addr  in  32  byte address.
- wtData  in  32  write data.
- rdData  out  32  read data, combinational.
- intimer  out  1  timer interrupt request to the CPU, level, active-high.

Behaviour:
- Hit = ce && addr[31:5]==BASE_ADDR[31:5]. Register select is addr[4:2]. addr[1:0] are ignored.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 IE, bit2 AUTO (auto-reload). Other bits read 0.
  - 0x04 PRESCALE.
  - 0x08 LOAD.
  - 0x0C COUNT: read/write.
  - 0x10 STATUS: bit0 PEND, write-1-to-clear.
  - 0x14..0x1C: reserved. Reads return 0, writes are ignored.
- Reset (rst=0, async): CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, PEND=0, prescale counter PC=0. Outputs: intimer=0, and rdData=0 because ce is low.
- Write: on a rising edge with hit && we. The selected register takes wtData truncated to its width.
- Read: rdData = selected register, zero-extended, when hit && !we. Otherwise rdData=0. No wait states, zero latency.
- Prescaler:
  - When EN=1, PC increments each cycle.
  - When PC==PRESCALE, `tick` asserts for one cycle and PC wraps to 0.
  - When EN=0, PC holds at 0.
  - A write to CTRL that sets EN from 0 to 1 forces PC=0.
- Counter, evaluated on each tick:
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: expiry. PEND sets to 1. If AUTO=1, COUNT reloads from LOAD. If AUTO=0, COUNT stays 0 and EN clears to 0 (one-shot).
- Expiry period with AUTO=1 is (LOAD+1)*(PRESCALE+1) cycles.
- intimer = PEND && IE. It is driven from registers only, with no combinational path from bus inputs.
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick: the bus write wins and the tick's update of that register is dropped. PEND is still set if the tick was an expiry.
  - A STATUS W1C in the same cycle as an expiry: set wins, so PEND=1.
  - A write to LOAD does not change COUNT.
- LOAD=0 with AUTO=1: expiry on every tick. PEND stays set until cleared.
- Clearing EN mid-count freezes COUNT and resets PC to 0. Setting EN again resumes from the frozen COUNT.
- Reset asserted mid-count returns all state to reset values immediately, without waiting for clk. After release the timer stays idle until software programs it.

Test Plan:
1. Reset, then read all registers -> every read returns 0 and intimer=0. Access to reserved offset 0x18 -> read 0, write has no effect.
2. PRESCALE=0, LOAD=4, COUNT=4, CTRL=0x7 -> PEND sets 5 cycles after enable and intimer=1. Auto-reload keeps a 5-cycle period. STATUS write 0x1 -> intimer=0 next cycle.
3. PRESCALE=3, COUNT=2, CTRL=0x3 (one-shot) -> expiry at cycle 12. After expiry EN=0 and COUNT holds 0, with no further expiries over 50 cycles.
4. Expiry coinciding with a STATUS W1C write -> PEND remains 1. COUNT write coinciding with a tick -> COUNT equals the written value.
5. IE=0 during expiry -> PEND=1 but intimer=0. Then setting IE=1 -> intimer=1 on the next cycle.
6. Assert rst low between clock edges mid-count (COUNT=7, PC=2) -> all registers and intimer go to 0 immediately. After release the timer stays idle until reprogrammed.

Source files
------------

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped prescaled down-counter that raises the CPU timer interrupt.
// CTRL/PRESCALE/LOAD/COUNT/STATUS live in a 32-byte window at BASE_ADDR.
module timer_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 32,
    parameter int          PRE_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        intimer
);
    logic             r_en, r_ie, r_auto, r_pend;
    logic [PRE_W-1:0] r_pre, r_pc;
    logic [CNT_W-1:0] r_load, r_count;
    logic             w_hit, w_wr, w_tick, w_expire, w_en_nxt, w_unused;
    logic [2:0]       w_sel;

    assign w_hit    = ce && (addr[31:5] == BASE_ADDR[31:5]);
    assign w_sel    = addr[4:2];
    assign w_wr     = w_hit && we;
    assign w_tick   = r_en && (r_pc == r_pre);
    assign w_expire = w_tick && (r_count == '0);
    // a CTRL write overrides the one-shot disable from a same-cycle expiry
    assign w_en_nxt = (w_wr && w_sel == 3'd0) ? wtData[0] : (r_en && !(w_expire && !r_auto));
    assign intimer  = r_pend && r_ie;
    assign w_unused = &{1'b0, addr[1:0], wtData};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_auto  <= 1'b0;
            r_pend  <= 1'b0;
            r_pre   <= '0;
            r_pc    <= '0;
            r_load  <= '0;
            r_count <= '0;
        end else begin
            r_en <= w_en_nxt;
            if (w_wr && w_sel == 3'd0) begin
                r_ie   <= wtData[1];
                r_auto <= wtData[2];
            end
            if (w_wr && w_sel == 3'd1) r_pre <= wtData[PRE_W-1:0];
            if (w_wr && w_sel == 3'd2) r_load <= wtData[CNT_W-1:0];
            if (w_wr && w_sel == 3'd3) r_count <= wtData[CNT_W-1:0];
            else if (w_tick) r_count <= (r_count != '0) ? r_count - CNT_W'(1) : (r_auto ? r_load : '0);
            // expiry set beats a same-cycle W1C
            if (w_expire) r_pend <= 1'b1;
            else if (w_wr && w_sel == 3'd4 && wtData[0]) r_pend <= 1'b0;
            // PC restarts on enable, on disable and on wrap
            r_pc <= (!r_en || !w_en_nxt || w_tick) ? '0 : r_pc + PRE_W'(1);
        end
    end

    always_comb begin
        rdData = '0;
        if (w_hit && !we)
            case (w_sel)
                3'd0:    rdData = {29'd0, r_auto, r_ie, r_en};
                3'd1:    rdData = 32'(r_pre);
                3'd2:    rdData = 32'(r_load);
                3'd3:    rdData = 32'(r_count);
                3'd4:    rdData = {31'd0, r_pend};
                default: rdData = '0;
            endcase
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: scoreboard bench for timer_unit; expectations queued at stimulus, popped at sampling.
module tb_timer_unit;
    localparam logic [31:0] B = 32'h0000_1000;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wtData = '0, rdData;
    logic        intimer;
    int          n_vec = 0, n_err = 0;
    string       nm_q[$];
    logic [31:0] ex_q[$];

    timer_unit dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr),
        .wtData(wtData), .rdData(rdData), .intimer(intimer)
    );

    always #5 clk = ~clk;

    task automatic push(input string n, input logic [31:0] v);
        nm_q.push_back(n);
        ex_q.push_back(v);
    endtask

    // write is presented now and retires at the next posedge; returns at the following negedge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; wtData = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 d = rdData;
        ce = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] got, w;
        string n;
        rst = 1'b0;
        #1;
        push("rst_intimer", 0);
        got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        push("rst_rddata", 0);
        got = rdData;
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) push($sformatf("rst_reg%0d", i), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd(B + 32'(4 * i), got);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        @(negedge clk);
        wr(B + 32'h18, 32'hFFFF_FFFF);
        wr(32'h0000_2004, 32'h55);
        for (int i = 0; i < 8; i++) push($sformatf("rsv_reg%0d", i), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd(B + 32'(4 * i), got);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        wr(B + 32'h4, 32'hABCD_1234);
        push("pre_trunc_lowbits", 32'h1234);
        rd(B + 32'h6, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
    endtask

    task automatic test_autoreload;
        logic [31:0] got, w;
        string n;
        wr(B + 32'h4, 0);
        wr(B + 32'h8, 4);
        wr(B + 32'hC, 4);
        wr(B + 32'h0, 7);
        for (int c = 1; c <= 10; c++) begin
            push($sformatf("ar_cnt_c%0d", c), (c % 5 == 0) ? 32'd4 : 32'(4 - c % 5));
            push($sformatf("ar_int_c%0d", c), (c >= 5) ? 32'd1 : 32'd0);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rd(B + 32'hC, got);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
            got = 32'(intimer);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        wr(B + 32'h10, 1);
        for (int c = 11; c <= 15; c++) push($sformatf("ar_w1c_int_c%0d", c), (c == 15) ? 32'd1 : 32'd0);
        for (int c = 11; c <= 15; c++) begin
            if (c > 11) @(negedge clk);
            got = 32'(intimer);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        push("ar_ctrl", 7);
        rd(B, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
    endtask

    task automatic test_oneshot;
        logic [31:0] got, w;
        string n;
        wr(B, 0);
        wr(B + 32'h10, 1);
        wr(B + 32'h4, 3);
        wr(B + 32'hC, 2);
        wr(B, 3);
        for (int c = 1; c <= 12; c++) push($sformatf("os_int_c%0d", c), (c >= 12) ? 32'd1 : 32'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            got = 32'(intimer);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        push("os_ctrl_en_clr", 2);
        push("os_cnt_zero", 0);
        rd(B, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        wr(B + 32'h10, 1);
        for (int c = 0; c < 50; c++) push($sformatf("os_quiet_%0d", c), 0);
        for (int c = 0; c < 50; c++) begin
            got = 32'(intimer);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
            @(negedge clk);
        end
        push("os_cnt_held", 0);
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
    endtask

    task automatic test_collisions;
        logic [31:0] got, w;
        string n;
        wr(B, 0);
        wr(B + 32'h10, 1);
        wr(B + 32'h4, 0);
        wr(B + 32'h8, 0);
        wr(B + 32'hC, 0);
        wr(B, 7);
        push("col_pre_int", 0);
        got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        wr(B + 32'h10, 1);
        push("col_w1c_vs_set", 1);
        rd(B + 32'h10, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        wr(B + 32'hC, 32'h20);
        push("col_cnt_wr_wins", 32'h20);
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        wr(B + 32'h8, 32'h55);
        push("col_load_no_cnt", 32'h1F);
        push("col_load_val", 32'h55);
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        rd(B + 32'h8, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        wr(B, 0);
        wr(B + 32'hC, 0);
        wr(B, 3);
        wr(B, 3);
        push("col_ctrl_wr_wins", 3);
        rd(B, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
        push("col_oneshot_clr", 2);
        rd(B, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
    endtask

    task automatic test_ie_gate;
        logic [31:0] got, w;
        string n;
        wr(B, 0);
        wr(B + 32'h10, 1);
        wr(B + 32'h4, 0);
        wr(B + 32'hC, 1);
        wr(B, 1);
        push("ie_pend_c1", 0);
        push("ie_pend_c2", 1);
        push("ie_int_masked", 0);
        push("ie_no_comb_path", 0);
        push("ie_int_on", 1);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            rd(B + 32'h10, got);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        ce = 1'b1; we = 1'b1; addr = B; wtData = 2;
        #1 got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        logic [31:0] got, w;
        string n;
        wr(B, 0);
        wr(B + 32'h4, 3);
        wr(B + 32'h8, 9);
        wr(B + 32'hC, 7);
        wr(B, 7);
        push("ar_int_before", 1);
        push("ar_cnt_before", 7);
        push("ar_int_async", 0);
        push("ar_cnt_async", 0);
        got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
        @(negedge clk);
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        #1 rst = 1'b0;
        #1 got = 32'(intimer);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        rd(B + 32'hC, got);
        w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
        if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) push($sformatf("ar_idle_int_%0d", c), 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got = 32'(intimer);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
        for (int i = 0; i < 5; i++) push($sformatf("ar_idle_reg%0d", i), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd(B + 32'(4 * i), got);
            w = ex_q.pop_front(); n = nm_q.pop_front(); n_vec++;
            if (got !== w) begin n_err++; $display("FAIL %s: got 0x%08h want 0x%08h", n, got, w); end
        end
    endtask

    initial begin
        test_reset;
        test_autoreload;
        test_oneshot;
        test_collisions;
        test_ie_gate;
        test_async_reset;
        if (ex_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", ex_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
